// File: rtl/ads124x_pkg.sv
// Shared sample format for the ADS124x controller and the decimator stages.
package ads124x_pkg;

    // Bit positions and widths of the 56-bit sample word.
    localparam int CODE_LSB = 0;
    localparam int CODE_W   = 24;
    localparam int CH_LSB   = 24;
    localparam int CH_W     = 3;
    localparam int RSVD_LSB = 27;
    localparam int RSVD_W   = 5;
    localparam int TS_LSB   = 32;
    localparam int TS_W     = 24;
    localparam int SAMPLE_W = 56;

    // One sample as it travels on the AXI4-Stream bus.
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [RSVD_W-1:0] rsvd;
        logic [CH_W-1:0]   ch;
        logic [CODE_W-1:0] code;
    } ads124x_sample_t;

    // Builds a sample word with the reserved field cleared.
    function automatic ads124x_sample_t make_sample(
        input logic [TS_W-1:0]   ts,
        input logic [CH_W-1:0]   ch,
        input logic [CODE_W-1:0] code
    );
        ads124x_sample_t s;
        s.ts   = ts;
        s.rsvd = '0;
        s.ch   = ch;
        s.code = code;
        return s;
    endfunction

endpackage

// File: rtl/ads124x_decim.sv
// Per-channel averaging decimator: each channel averages 2^cfg_log2_n
// consecutive samples and emits one sample in the same 56-bit format.
module ads124x_decim #(
    parameter int CHANNELS   = 8,
    parameter int MAX_LOG2_N = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cfg_log2_n,
    input  logic [55:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [55:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        stat_flush
);
    import ads124x_pkg::*;

    // The accumulator holds exactly N full-scale samples, so it never wraps.
    localparam int ACC_W = CODE_W + MAX_LOG2_N;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Configuration pipeline: current registered exponent and the one before it.
    logic [2:0] r_cfg;
    logic [2:0] r_cfgPrev;
    logic       r_flush;

    // Per-channel running sums and beat counters.
    logic signed [ACC_W-1:0]      r_acc [CHANNELS];
    logic        [MAX_LOG2_N-1:0] r_cnt [CHANNELS];

    // Output register.
    logic            r_outValid;
    ads124x_sample_t r_outData;

    ads124x_sample_t         w_inSample;
    logic                    w_cfgChange;
    logic [2:0]              w_log2n;
    logic [2:0]              w_chMod;
    logic [IDX_W-1:0]        w_idx;
    logic signed [ACC_W-1:0] w_codeExt;
    logic signed [ACC_W-1:0] w_sum;
    logic [CODE_W-1:0]       w_avgCode;
    logic [MAX_LOG2_N-1:0]   w_lastCnt;
    logic                    w_isLast;
    logic                    w_accept;
    logic                    w_unusedRsvd;

    assign w_inSample   = ads124x_sample_t'(s_axis_tdata);
    assign w_unusedRsvd = ^w_inSample.rsvd;

    // A difference between the two pipeline stages means a new exponent just arrived.
    assign w_cfgChange = (r_cfg != r_cfgPrev);

    // Exponents beyond what the accumulator can hold are clamped.
    assign w_log2n = (32'(r_cfg) > MAX_LOG2_N) ? 3'(MAX_LOG2_N) : r_cfg;

    // Channel slot is the channel field modulo CHANNELS (a power of two).
    assign w_chMod = w_inSample.ch & 3'(CHANNELS - 1);
    assign w_idx   = w_chMod[IDX_W-1:0];

    // Read-modify-write of the selected accumulator; the array is updated at
    // the clock edge so a following beat on the same channel sees the new sum.
    assign w_codeExt = {{MAX_LOG2_N{w_inSample.code[CODE_W-1]}}, w_inSample.code};
    assign w_sum     = r_acc[w_idx] + w_codeExt;
    assign w_avgCode = 24'(w_sum >>> w_log2n);

    // N-1 as a mask of w_log2n low ones; for N = 1 every beat is the last one.
    assign w_lastCnt = ~({MAX_LOG2_N{1'b1}} << w_log2n);
    assign w_isLast  = (r_cnt[w_idx] == w_lastCnt);

    // Accept when the output register is free or draining, except while clearing.
    assign s_axis_tready = (!r_outValid || m_axis_tready) && !w_cfgChange;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = r_outData;
    assign m_axis_tvalid = r_outValid;
    assign stat_flush    = r_flush;

    // Register the exponent; reset preloads both stages so no flush follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg     <= cfg_log2_n;
            r_cfgPrev <= cfg_log2_n;
        end else begin
            r_cfg     <= cfg_log2_n;
            r_cfgPrev <= r_cfg;
        end
    end

    // Flush pulse is emitted in the cycle after the accumulators are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_cfgChange;
        end
    end

    // Accumulate accepted beats; clear a channel when its window completes.
    always_ff @(posedge clk) begin
        if (rst || w_cfgChange) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            if (w_isLast) begin
                r_acc[w_idx] <= '0;
                r_cnt[w_idx] <= '0;
            end else begin
                r_acc[w_idx] <= w_sum;
                r_cnt[w_idx] <= r_cnt[w_idx] + MAX_LOG2_N'(1);
            end
        end
    end

    // Output register: load on a completed window, hold until popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_accept && w_isLast) begin
            r_outValid <= 1'b1;
            r_outData  <= make_sample(w_inSample.ts, w_chMod, w_avgCode);
        end else if (m_axis_tready) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ads124x_decim.sv
// Self-checking bench for ads124x_decim with a windowed-average reference model.
module tb_ads124x_decim;

    localparam int CHANNELS   = 8;
    localparam int MAX_LOG2_N = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cfg_log2_n;
    logic [55:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [55:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        stat_flush;

    int nChecks = 0;
    int nFails  = 0;

    logic [55:0] obsQ[$];
    logic [55:0] expQ[$];
    longint      modelSum [CHANNELS];
    int          modelCnt [CHANNELS];
    int          modelLog2;
    int          curCfg;

    always #5 clk = ~clk;

    ads124x_decim #(.CHANNELS(CHANNELS), .MAX_LOG2_N(MAX_LOG2_N)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_log2_n(cfg_log2_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .stat_flush(stat_flush)
    );

    // Reference model: forget all partial windows.
    function automatic void modelClear();
        for (int i = 0; i < CHANNELS; i++) begin
            modelSum[i] = 0;
            modelCnt[i] = 0;
        end
    endfunction

    function automatic logic [55:0] mkWord(input logic [23:0] ts, input logic [2:0] ch, input logic [23:0] code);
        return {ts, 5'b00000, ch, code};
    endfunction

    // Reference model: add a sample to its channel; after N samples emit the floor of the mean.
    function automatic void modelBeat(input logic [55:0] w);
        int     ch;
        longint x, n, s, q;
        ch = int'(w[26:24]) % CHANNELS;
        x  = longint'($signed(w[23:0]));
        n  = longint'(1) << modelLog2;
        modelSum[ch] += x;
        modelCnt[ch] += 1;
        if (modelCnt[ch] == n) begin
            s = modelSum[ch];
            if (s >= 0) q = s / n;
            else        q = -((-s + n - 1) / n);
            expQ.push_back({w[55:32], 5'b00000, 3'(ch), q[23:0]});
            modelSum[ch] = 0;
            modelCnt[ch] = 0;
        end
    endfunction

    // One clock: observe handshakes just before the edge, then land 1 time unit after it.
    task automatic tick(output bit accepted);
        #2;
        accepted = s_axis_tvalid && s_axis_tready && !rst;
        if (m_axis_tvalid && m_axis_tready && !rst) obsQ.push_back(m_axis_tdata);
        if (accepted) modelBeat(s_axis_tdata);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        s_axis_tvalid = 1'b0;
        repeat (n) tick(a);
    endtask

    // Present one beat and wait (bounded) for it to be accepted; leaves tvalid high.
    task automatic sendBeat(input logic [55:0] w);
        bit a;
        int guard;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        a = 1'b0;
        guard = 0;
        while (!a && guard < 200) begin
            tick(a);
            guard++;
        end
        if (!a) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL sendBeat timeout: beat %h not accepted, required acceptance within 200 cycles", w);
        end
    endtask

    // Change the exponent while idle and let the flush complete before more traffic.
    task automatic setCfg(input int v);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        cfg_log2_n    = 3'(v);
        idle(4);
        if (v != curCfg) modelClear();
        curCfg    = v;
        modelLog2 = (v > MAX_LOG2_N) ? MAX_LOG2_N : v;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        cfg_log2_n    = 3'd0;
        curCfg        = 0;
        modelLog2     = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear();
        obsQ.delete();
        expQ.delete();
        nChecks++; if (m_axis_tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tvalid: got %b, expected 0", m_axis_tvalid); end
        nChecks++; if (m_axis_tdata !== 56'd0) begin nFails++; $display("[TB] FAIL reset_tdata: got %h, expected 0", m_axis_tdata); end
        nChecks++; if (stat_flush !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flush: got %b, expected 0", stat_flush); end
        nChecks++; if (s_axis_tready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_tready: got %b, expected 1", s_axis_tready); end
    endtask

    task automatic test_passthrough();
        logic [55:0] expW;
        expW = mkWord(24'h00ABCD, 3'd2, 24'h123456);
        sendBeat({24'h00ABCD, 5'b10101, 3'd2, 24'h123456});
        s_axis_tvalid = 1'b0;
        nChecks++; if (m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL pass_latency: tvalid %b, expected 1", m_axis_tvalid); end
        nChecks++; if (m_axis_tdata !== expW) begin nFails++; $display("[TB] FAIL pass_data: got %h, expected %h", m_axis_tdata, expW); end
        idle(3);
        nChecks++; if (obsQ.size() != expQ.size()) begin nFails++; $display("[TB] FAIL pass_count: got %0d words, expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL pass_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_basic_average();
        logic [55:0] expW;
        int codes[4] = '{10, 20, 30, 41};
        setCfg(2);
        for (int i = 0; i < 4; i++) sendBeat(mkWord(24'(32'h100 + i), 3'd0, 24'(codes[i])));
        s_axis_tvalid = 1'b0;
        expW = mkWord(24'h000103, 3'd0, 24'd25);
        nChecks++; if (m_axis_tdata !== expW || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL avg_data: got %h valid %b, expected %h valid 1", m_axis_tdata, m_axis_tvalid, expW); end
        sendBeat(mkWord(24'h000200, 3'd0, 24'd7));
        idle(4);
        nChecks++; if (obsQ.size() != 1) begin nFails++; $display("[TB] FAIL avg_count: got %0d words, expected 1", obsQ.size()); end
        nChecks++; if (obsQ.size() != expQ.size()) begin nFails++; $display("[TB] FAIL avg_model_count: got %0d words, expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL avg_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_interleave();
        logic [55:0] expA, expB;
        setCfg(1);
        sendBeat(mkWord(24'h000011, 3'd1, 24'hFFFFFD));
        sendBeat(mkWord(24'h000012, 3'd5, 24'd100));
        sendBeat(mkWord(24'h000013, 3'd1, 24'd0));
        expA = mkWord(24'h000013, 3'd1, 24'hFFFFFE);
        nChecks++; if (m_axis_tdata !== expA || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL ilv_ch1: got %h valid %b, expected %h", m_axis_tdata, m_axis_tvalid, expA); end
        sendBeat(mkWord(24'h000014, 3'd5, 24'd101));
        s_axis_tvalid = 1'b0;
        expB = mkWord(24'h000014, 3'd5, 24'd100);
        nChecks++; if (m_axis_tdata !== expB || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL ilv_ch5: got %h valid %b, expected %h", m_axis_tdata, m_axis_tvalid, expB); end
        idle(3);
        nChecks++; if (obsQ.size() != expQ.size()) begin nFails++; $display("[TB] FAIL ilv_count: got %0d words, expected %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL ilv_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_extremes();
        logic [23:0] vals[2] = '{24'h800000, 24'h7FFFFF};
        logic [55:0] expW;
        time t0;
        setCfg(7);
        for (int v = 0; v < 2; v++) begin
            t0 = $time;
            for (int i = 0; i < 128; i++) sendBeat(mkWord(24'(i + 256 * v), 3'd7, vals[v]));
            s_axis_tvalid = 1'b0;
            expW = mkWord(24'(127 + 256 * v), 3'd7, vals[v]);
            nChecks++; if (m_axis_tdata !== expW || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL ext_val%0d: got %h valid %b, expected %h", v, m_axis_tdata, m_axis_tvalid, expW); end
            nChecks++; if ($time - t0 != 128 * 10) begin nFails++; $display("[TB] FAIL ext_rate%0d: took %0t, expected %0t", v, $time - t0, 128 * 10); end
            idle(2);
        end
        nChecks++; if (obsQ.size() != 2 || expQ.size() != 2) begin nFails++; $display("[TB] FAIL ext_count: got %0d words, expected 2 (model %0d)", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL ext_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_backpressure();
        logic [55:0] wA, wB;
        bit a;
        setCfg(0);
        wA = mkWord(24'h000001, 3'd3, 24'h000111);
        wB = mkWord(24'h000002, 3'd6, 24'hABCDEF);
        m_axis_tready = 1'b0;
        sendBeat(wA);
        s_axis_tdata = wB;
        for (int i = 0; i < 3; i++) begin
            tick(a);
            nChecks++; if (a !== 1'b0) begin nFails++; $display("[TB] FAIL bp_tready%0d: beat accepted while output stalled", i); end
            nChecks++; if (m_axis_tdata !== wA || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_hold%0d: got %h valid %b, expected %h", i, m_axis_tdata, m_axis_tvalid, wA); end
        end
        m_axis_tready = 1'b1;
        #2;
        nChecks++; if (s_axis_tready !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_ready: got %b, expected 1", s_axis_tready); end
        tick(a);
        s_axis_tvalid = 1'b0;
        nChecks++; if (a !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_accept: got %b, expected 1", a); end
        nChecks++; if (m_axis_tdata !== wB || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_next: got %h valid %b, expected %h", m_axis_tdata, m_axis_tvalid, wB); end
        idle(3);
        nChecks++; if (obsQ.size() != 2) begin nFails++; $display("[TB] FAIL bp_count: got %0d words, expected 2", obsQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL bp_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_config_change();
        logic [55:0] expW;
        bit a;
        setCfg(1);
        sendBeat(mkWord(24'h000030, 3'd3, 24'd1000));
        idle(1);
        cfg_log2_n = 3'd2;
        tick(a);
        nChecks++; if (stat_flush !== 1'b0) begin nFails++; $display("[TB] FAIL cfg_flush_early: got %b, expected 0", stat_flush); end
        #2;
        nChecks++; if (s_axis_tready !== 1'b0) begin nFails++; $display("[TB] FAIL cfg_clear_ready: got %b, expected 0", s_axis_tready); end
        tick(a);
        nChecks++; if (stat_flush !== 1'b1) begin nFails++; $display("[TB] FAIL cfg_flush_pulse: got %b, expected 1", stat_flush); end
        tick(a);
        nChecks++; if (stat_flush !== 1'b0) begin nFails++; $display("[TB] FAIL cfg_flush_end: got %b, expected 0", stat_flush); end
        modelClear();
        curCfg = 2;
        modelLog2 = 2;
        for (int i = 0; i < 4; i++) sendBeat(mkWord(24'(32'h40 + i), 3'd3, 24'(4 * (i + 1))));
        s_axis_tvalid = 1'b0;
        expW = mkWord(24'h000043, 3'd3, 24'd10);
        nChecks++; if (m_axis_tdata !== expW || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL cfg_post_avg: got %h valid %b, expected %h", m_axis_tdata, m_axis_tvalid, expW); end
        idle(2);

        // Reset mid-window with a stalled output word.
        sendBeat(mkWord(24'h000050, 3'd3, 24'd5));
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) sendBeat(mkWord(24'(32'h60 + i), 3'd4, 24'(i + 1)));
        s_axis_tvalid = 1'b0;
        nChecks++; if (m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL rst_pending: got %b, expected 1", m_axis_tvalid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear();
        obsQ.delete(); expQ.delete();
        nChecks++; if (m_axis_tvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_tvalid: got %b, expected 0", m_axis_tvalid); end
        nChecks++; if (m_axis_tdata !== 56'd0) begin nFails++; $display("[TB] FAIL rst_mid_tdata: got %h, expected 0", m_axis_tdata); end
        nChecks++; if (s_axis_tready !== 1'b1 || stat_flush !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_ctrl: tready %b flush %b, expected 1 and 0", s_axis_tready, stat_flush); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) sendBeat(mkWord(24'(32'h70 + i), 3'd3, 24'd1));
        s_axis_tvalid = 1'b0;
        expW = mkWord(24'h000073, 3'd3, 24'd1);
        nChecks++; if (m_axis_tdata !== expW || m_axis_tvalid !== 1'b1) begin nFails++; $display("[TB] FAIL rst_post_avg: got %h valid %b, expected %h", m_axis_tdata, m_axis_tvalid, expW); end
        for (int i = 0; i < 4; i++) sendBeat(mkWord(24'(32'h80 + i), 3'd4, 24'd8));
        idle(3);
        nChecks++; if (obsQ.size() != 2 || expQ.size() != 2) begin nFails++; $display("[TB] FAIL rst_count: got %0d words, expected 2 (model %0d)", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL rst_word%0d: got %h, expected %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_random();
        int cfgs[5] = '{3, 1, 0, 4, 2};
        bit a;
        for (int r = 0; r < 5; r++) begin
            setCfg(cfgs[r]);
            a = 1'b1;
            for (int k = 0; k < 200; k++) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                if (!(s_axis_tvalid && !a)) begin
                    if ($urandom_range(0, 3) != 0) begin
                        s_axis_tvalid = 1'b1;
                        s_axis_tdata  = {24'(k + 1000 * r), 5'($urandom), 3'($urandom_range(0, 7)), 24'($urandom)};
                    end else begin
                        s_axis_tvalid = 1'b0;
                    end
                end
                tick(a);
            end
            m_axis_tready = 1'b1;
            idle(4);
            nChecks++; if (obsQ.size() != expQ.size()) begin nFails++; $display("[TB] FAIL rnd%0d_count: got %0d words, expected %0d", r, obsQ.size(), expQ.size()); end
            for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
                nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL rnd%0d_word%0d: got %h, expected %h", r, i, obsQ[i], expQ[i]); end
            end
            obsQ.delete(); expQ.delete();
        end
    endtask

    // Main sequence.
    initial begin
        test_reset();
        test_passthrough();
        test_basic_average();
        test_interleave();
        test_extremes();
        test_backpressure();
        test_config_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ads124x_decim.md
# ads124x_decim

Per-channel averaging decimator for the ADS124x sample stream. It sits directly downstream of the ADS124x controller's 56-bit AXI4-Stream sample output. For each channel it averages N = 2^cfg_log2_n consecutive samples and emits one sample in the same 56-bit format, so the output can feed the DMA/packer path in place of the raw stream.

## Interface
Reset is synchronous and active-high on `rst`; there is a single clock, `clk`.

Parameters:
- `CHANNELS`, default 8: number of channel slots. Must be a power of two, at most 8. The channel field is 3 bits.
- `MAX_LOG2_N`, default 7: largest decimation exponent supported.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_log2_n`  in  3  decimation exponent. N = 2^cfg_log2_n. Values above MAX_LOG2_N are clamped to MAX_LOG2_N.
- `s_axis_tdata`  in  56  input sample.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  56  averaged sample.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `stat_flush`  out  1  one-cycle pulse when the accumulators are cleared by a configuration change.

Sample format (used on both input and output):
- [23:0]: signed 24-bit ADC code.
- [26:24]: channel.
- [31:27]: zero.
- [55:32]: 24-bit tick count since the last PPS.

## Operation
Per-channel state:
- `acc[ch]`, signed, 24+MAX_LOG2_N bits (31 by default).
- `cnt[ch]`, MAX_LOG2_N bits.

Input handshake:
- `s_axis_tready = !m_axis_tvalid || m_axis_tready`. Input is only accepted when the output register is free or is draining in the same cycle.
- The channel field is taken modulo CHANNELS.

On each accepted beat (channel ch, code x):
- Compute `sum = acc[ch] + sign_extend(x)`.
- If `cnt[ch] == N-1`:
  - Load the output register: code = `sum >>> cfg_log2_n`, truncated to 24 bits. The shift is arithmetic (rounds toward −∞).
  - Channel = ch. Bits [31:27] = 0. Timestamp = timestamp of this (final) input beat.
  - Clear `acc[ch]` and `cnt[ch]` to 0.
- Otherwise: `acc[ch] <= sum`, `cnt[ch] <= cnt[ch] + 1`.
- N = 1 (`cfg_log2_n = 0`): every beat passes through unchanged, except that bits [31:27] are forced to 0.
- Overflow is impossible: the accumulator holds N samples exactly. Averaging −2^23 over 128 samples returns −2^23.

Configuration change:
- `cfg_log2_n` is registered internally every cycle.
- When the registered value differs from the previous one, all `acc` and `cnt` entries are cleared on the next cycle and `stat_flush` pulses.
- No input is accepted during the clear cycle: `s_axis_tready` is forced low for that cycle.
- A pending output word is not affected and is still delivered.

Output handshake:
- `m_axis_tvalid` stays asserted with `m_axis_tdata` stable until `m_axis_tready` is sampled high.
- Simultaneous output pop and input push in the same cycle is supported at full rate: one beat per clock.

Reset:
- `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `stat_flush = 0`.
- All `acc` and `cnt` entries = 0.
- `s_axis_tready = 1`.
- A reset asserted mid-window discards partial sums. An un-accepted output word is dropped.

## Timing
- Latency: 1 cycle from acceptance of the N-th beat of a channel to `m_axis_tvalid = 1`.
- Throughput: 1 beat per clock when `m_axis_tready` is held high.
- Back-to-back beats on the same channel must use the just-updated accumulator (read-after-write forwarding, or a flop array that is written and read in the same cycle).
- Configuration change: `stat_flush` pulses exactly 2 cycles after `cfg_log2_n` changes (input register, then clear).

## Structure
- Package `ads124x_pkg`:
  - Field offsets and widths: CODE_LSB = 0 / width 24; CH_LSB = 24 / width 3; TS_LSB = 32 / width 24.
  - `typedef struct packed` `ads124x_sample_t`, with fields ts, rsvd, ch, code.
  - Shared with the controller stage.
- Single module. Accumulators are implemented as flop arrays, since CHANNELS ≤ 8. No sub-module is needed.

## Test plan
- **Pass-through.** `cfg_log2_n = 0`; send code 0x123456, ch 2, ts 0x00ABCD. Expect the identical word 1 cycle later, with bits [31:27] = 0.
- **Basic average.** `cfg_log2_n = 2`; send ch 0 codes 10, 20, 30, 41. Expect one output: code 25, with ts equal to the 4th beat's ts. A following single beat produces no output.
- **Channel interleave and signed rounding.** `cfg_log2_n = 1`; send ch1 −3, ch5 100, ch1 0, ch5 101. Expect ch1 → −2 (−3 >>> 1), then ch5 → 100.
- **Extremes.** `cfg_log2_n = 7`; send 128 × 0x800000 on ch 7. Expect 0x800000 and no wrap. Repeat with 0x7FFFFF and expect 0x7FFFFF.
- **Backpressure.** Hold `m_axis_tready = 0` with an output pending. Expect `s_axis_tready = 0` and `m_axis_tdata` stable. Release and expect one word and resumed acceptance in the same cycle.
- **Configuration change and reset.** Change `cfg_log2_n` mid-window. Expect the `stat_flush` pulse, the partial sum discarded, and the next output to average only post-change samples. Assert `rst` mid-window and expect all outputs to return to their reset values.
